// File: rtl/mcpu_mem_ltc_bram_rdport_if.sv
`default_nettype none
// ============================================================================
// Module      : mcpu_mem_ltc_bram_rdport_if
// Description : Request/response handshake bundle for the LTC data-BRAM read
//               port front end. The master issues tagged line reads and
//               consumes responses. The slave is the read port.
// Revision    : 1.0 - initial release
// ============================================================================
interface mcpu_mem_ltc_bram_rdport_if #(
    parameter int DEPTH_BITS  = 9,
    parameter int WIDTH_BYTES = 32,
    parameter int TAG_BITS    = 4
);
    logic                       req_valid;
    logic                       req_ready;
    logic [DEPTH_BITS-1:0]      req_addr;
    logic [TAG_BITS-1:0]        req_tag;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [WIDTH_BYTES*8-1:0]   resp_data;
    logic [TAG_BITS-1:0]        resp_tag;

    modport master (
        output req_valid, req_addr, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag
    );

    modport slave (
        input  req_valid, req_addr, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag
    );
endinterface
`default_nettype wire

// File: rtl/mcpu_mem_ltc_bram_rdport.sv
`default_nettype none
// ============================================================================
// Module      : mcpu_mem_ltc_bram_rdport
// Description : Read-side front end for the LTC data BRAM. Accepts tagged
//               reads, drives the BRAM read pins, captures the registered
//               read data into a small response FIFO and returns it in order
//               with its tag under downstream backpressure.
//               Optional read-during-write forwarding is enabled by defining
//               MCPU_MEM_LTC_RDPORT_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mcpu_mem_ltc_bram_rdport #(
    parameter int DEPTH_BITS  = 9,
    parameter int WIDTH_BYTES = 32,
    parameter int TAG_BITS    = 4,
    parameter int RESP_DEPTH  = 3
) (
    input  wire                         clkrst_mem_clk,
    input  wire                         clkrst_mem_rst,
    mcpu_mem_ltc_bram_rdport_if.slave   bus,
    output logic                        bram_re,
    output logic [DEPTH_BITS-1:0]       bram_raddr,
    input  wire  [WIDTH_BYTES*8-1:0]    bram_rdata,
    input  wire  [DEPTH_BITS-1:0]       snp_waddr,
    input  wire  [WIDTH_BYTES-1:0]      snp_wbe,
    input  wire  [WIDTH_BYTES*8-1:0]    snp_wdata
);
    localparam int DATA_BITS = WIDTH_BYTES * 8;
    localparam int PTR_BITS  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_BITS  = $clog2(RESP_DEPTH + 1);
    localparam logic [PTR_BITS-1:0] LAST_PTR  = PTR_BITS'(RESP_DEPTH - 1);
    localparam logic [CNT_BITS:0]   DEPTH_CNT = (CNT_BITS + 1)'(RESP_DEPTH);

    logic [CNT_BITS-1:0]    occ;
    logic                   inflight;
    logic [TAG_BITS-1:0]    inflight_tag;
    logic [PTR_BITS-1:0]    wr_ptr;
    logic [PTR_BITS-1:0]    rd_ptr;
    logic [DATA_BITS-1:0]   fifo_data [RESP_DEPTH];
    logic [TAG_BITS-1:0]    fifo_tag  [RESP_DEPTH];
    logic                   acc;
    logic                   push;
    logic                   pop;
    logic [DATA_BITS-1:0]   capture_data;

    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_BITS'(1);
    endfunction

    // Only accept when the FIFO can hold every read already issued plus this
    // one; depends on registered state only, never on resp_ready.
    assign bus.req_ready = ({1'b0, occ} + {{CNT_BITS{1'b0}}, inflight}) < DEPTH_CNT;
    assign acc           = bus.req_valid & bus.req_ready;
    assign bram_re       = acc;
    assign bram_raddr    = bus.req_addr;

    assign push           = inflight;
    assign bus.resp_valid = (occ != '0);
    assign pop            = bus.resp_valid & bus.resp_ready;
    assign bus.resp_data  = fifo_data[rd_ptr];
    assign bus.resp_tag   = fifo_tag[rd_ptr];

`ifdef MCPU_MEM_LTC_RDPORT_BYPASS_EN
    logic [WIDTH_BYTES-1:0] byp_be;
    logic [DATA_BITS-1:0]   byp_data;

    // Remember a same-address write seen in the accept cycle so the capture
    // reflects it instead of the BRAM's pre-write data.
    always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
        if (clkrst_mem_rst) begin
            byp_be   <= '0;
            byp_data <= '0;
        end else if (acc && (snp_waddr == bus.req_addr) && (snp_wbe != '0)) begin
            byp_be   <= snp_wbe;
            byp_data <= snp_wdata;
        end else begin
            byp_be   <= '0;
        end
    end

    for (genvar b = 0; b < WIDTH_BYTES; b++) begin : g_merge
        assign capture_data[b*8 +: 8] = byp_be[b] ? byp_data[b*8 +: 8]
                                                  : bram_rdata[b*8 +: 8];
    end
`else
    logic unused_snoop;
    assign unused_snoop = ^{snp_waddr, snp_wbe, snp_wdata};
    assign capture_data = bram_rdata;
`endif

    // Track the single outstanding BRAM read and the tag that travels with it.
    always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
        if (clkrst_mem_rst) begin
            inflight     <= 1'b0;
            inflight_tag <= '0;
        end else begin
            inflight     <= acc;
            inflight_tag <= bus.req_tag;
        end
    end

    // FIFO storage; cleared on reset so the head presents zero data and tag.
    always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
        if (clkrst_mem_rst) begin
            for (int i = 0; i < RESP_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_tag[i]  <= '0;
            end
        end else if (push) begin
            fifo_data[wr_ptr] <= capture_data;
            fifo_tag[wr_ptr]  <= inflight_tag;
        end
    end

    // Circular pointers and occupancy; push+pop together leaves occ unchanged.
    always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
        if (clkrst_mem_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CNT_BITS'(1);
                2'b01:   occ <= occ - CNT_BITS'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mcpu_mem_ltc_bram_rdport.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcpu_mem_ltc_bram_rdport
// Description : Directed self-checking bench for the LTC BRAM read port with
//               a behavioural registered-read BRAM and an in-order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcpu_mem_ltc_bram_rdport;
    localparam int DEPTH_BITS  = 9;
    localparam int WIDTH_BYTES = 32;
    localparam int TAG_BITS    = 4;
    localparam int RESP_DEPTH  = 3;

    logic         clkrst_mem_clk = 1'b0;
    logic         clkrst_mem_rst = 1'b1;
    logic         bram_re;
    logic [8:0]   bram_raddr;
    logic [255:0] bram_rdata = '0;
    logic [8:0]   snp_waddr  = '0;
    logic [31:0]  snp_wbe    = '0;
    logic [255:0] snp_wdata  = '0;

    mcpu_mem_ltc_bram_rdport_if #(
        .DEPTH_BITS(DEPTH_BITS), .WIDTH_BYTES(WIDTH_BYTES), .TAG_BITS(TAG_BITS)
    ) bus ();

    mcpu_mem_ltc_bram_rdport #(
        .DEPTH_BITS(DEPTH_BITS), .WIDTH_BYTES(WIDTH_BYTES),
        .TAG_BITS(TAG_BITS), .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clkrst_mem_clk (clkrst_mem_clk),
        .clkrst_mem_rst (clkrst_mem_rst),
        .bus            (bus.slave),
        .bram_re        (bram_re),
        .bram_raddr     (bram_raddr),
        .bram_rdata     (bram_rdata),
        .snp_waddr      (snp_waddr),
        .snp_wbe        (snp_wbe),
        .snp_wdata      (snp_wdata)
    );

    always #5 clkrst_mem_clk = ~clkrst_mem_clk;

    typedef struct packed {
        logic [255:0] data;
        logic [3:0]   tag;
    } exp_t;

    exp_t         exp_q[$];
    logic [255:0] mem [512];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           m_occ    = 0;
    logic         m_inflight = 1'b0;
    logic         re_s = 1'b0;
    logic [8:0]   ra_s = '0;
    logic         s_acc, s_pop;
    logic [255:0] s_data;
    logic [3:0]   s_tag;

    function automatic logic [255:0] pat(input logic [8:0] a);
        logic [255:0] r;
        for (int b = 0; b < 32; b++) r[b*8 +: 8] = a[7:0] + 8'(b);
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, expv);
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, model BRAM at posedge+1.
    task automatic step(input logic v, input logic [8:0] a, input logic [3:0] t, input logic rr,
                        input logic [31:0] wbe, input logic [8:0] wa, input logic [255:0] wd);
        logic         exp_ready;
        logic [255:0] line;
        exp_t         head;
        bus.req_valid  = v;
        bus.req_addr   = a;
        bus.req_tag    = t;
        bus.resp_ready = rr;
        snp_wbe   = wbe;
        snp_waddr = wa;
        snp_wdata = wd;
        @(negedge clkrst_mem_clk);
        exp_ready = (m_occ + int'(m_inflight)) < RESP_DEPTH;
        s_acc = v & exp_ready;
        s_pop = (m_occ != 0) & rr;
        check("req_ready", 256'(bus.req_ready), 256'(exp_ready));
        check("resp_valid", 256'(bus.resp_valid), 256'(m_occ != 0));
        check("bram_re", 256'(bram_re), 256'(s_acc));
        check("occ", 256'(dut.occ), 256'(m_occ));
        if (s_acc) check("bram_raddr", 256'(bram_raddr), 256'(a));
        s_data = '0;
        s_tag  = '0;
        if (m_occ != 0) begin
            head = exp_q[0];
            check("resp_data", bus.resp_data, head.data);
            check("resp_tag", 256'(bus.resp_tag), 256'(head.tag));
            s_data = bus.resp_data;
            s_tag  = bus.resp_tag;
        end
        if (s_acc) begin
            line = mem[a];
`ifdef MCPU_MEM_LTC_RDPORT_BYPASS_EN
            if (wa == a && wbe != '0)
                for (int b = 0; b < 32; b++) if (wbe[b]) line[b*8 +: 8] = wd[b*8 +: 8];
`endif
            exp_q.push_back({line, t});
        end
        if (s_pop) void'(exp_q.pop_front());
        re_s = bram_re;
        ra_s = bram_raddr;
        @(posedge clkrst_mem_clk);
        m_occ      = m_occ + int'(m_inflight) - int'(s_pop);
        m_inflight = s_acc;
        #1;
        if (re_s) bram_rdata = mem[ra_s];
        for (int b = 0; b < 32; b++) if (wbe[b]) mem[wa][b*8 +: 8] = wd[b*8 +: 8];
    endtask

    task automatic stepr(input logic v, input logic [8:0] a, input logic [3:0] t, input logic rr);
        step(v, a, t, rr, 32'h0, 9'h0, 256'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           p, pops, cnt, cyc, first_pop, last_pop;
        logic [255:0] exp_line;
        for (int i = 0; i < 512; i++) mem[i] = pat(9'(i));
        mem[5]        = {32{8'hA5}};
        mem[16][7:0]  = 8'h11;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_tag   = '0;
        bus.resp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clkrst_mem_clk);
        #1;
        check("rst_req_ready", 256'(bus.req_ready), 256'(1'b1));
        check("rst_resp_valid", 256'(bus.resp_valid), 256'(1'b0));
        check("rst_bram_re", 256'(bram_re), 256'(1'b0));
        check("rst_resp_data", bus.resp_data, 256'h0);
        check("rst_resp_tag", 256'(bus.resp_tag), 256'h0);
        clkrst_mem_rst = 1'b0;

        // Single read, load-to-use of two cycles
        stepr(1'b1, 9'h005, 4'h3, 1'b1);
        check("single_acc", 256'(s_acc), 256'(1'b1));
        stepr(1'b0, 9'h000, 4'h0, 1'b1);
        check("single_n1_no_resp", 256'(s_pop), 256'(1'b0));
        stepr(1'b0, 9'h000, 4'h0, 1'b1);
        check("single_n2_resp", 256'(s_pop), 256'(1'b1));
        check("single_data", s_data, {32{8'hA5}});
        check("single_tag", 256'(s_tag), 256'(4'h3));
        stepr(1'b0, 9'h000, 4'h0, 1'b1);

        // Back-to-back reads with resp_ready held high
        cnt = 0; pops = 0; first_pop = -1; last_pop = -1;
        for (int i = 0; i < 11; i++) begin
            stepr(i < 8, 9'(i), 4'(i), 1'b1);
            if (s_acc) cnt++;
            if (s_pop) begin
                pops++;
                if (first_pop < 0) first_pop = i;
                last_pop = i;
            end
        end
        check("b2b_accepted", 256'(cnt), 256'(8));
        check("b2b_responses", 256'(pops), 256'(8));
        check("b2b_consecutive", 256'(last_pop - first_pop), 256'(7));

        // Backpressure: five requests offered with resp_ready low
        p = 0;
        for (int i = 0; i < 5; i++) begin
            stepr(1'b1, 9'(32 + p), 4'(p), 1'b0);
            if (s_acc) p++;
        end
        check("bp_accepted", 256'(p), 256'(3));
        check("bp_ready_low", 256'(bus.req_ready), 256'(1'b0));
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            stepr(p < 5, 9'(32 + p), 4'(p), 1'b1);
            if (s_acc) p++;
            if (s_pop) pops++;
        end
        check("bp_all_accepted", 256'(p), 256'(5));
        check("bp_all_returned", 256'(pops), 256'(5));

        // Same-address write in the accept cycle
        step(1'b1, 9'h010, 4'hA, 1'b1, 32'h1, 9'h010, 256'hFF);
        stepr(1'b0, 9'h000, 4'h0, 1'b1);
        stepr(1'b0, 9'h000, 4'h0, 1'b1);
        check("rdw_pop", 256'(s_pop), 256'(1'b1));
`ifdef MCPU_MEM_LTC_RDPORT_BYPASS_EN
        check("rdw_byte0", 256'(s_data[7:0]), 256'(8'hFF));
`else
        check("rdw_byte0", 256'(s_data[7:0]), 256'(8'h11));
`endif
        check("rdw_byte1", 256'(s_data[15:8]), 256'(8'h11));

        // Simultaneous push and pop at occ = 2
        for (int i = 0; i < 3; i++) stepr(1'b1, 9'(64 + i), 4'(i + 5), 1'b0);
        stepr(1'b0, 9'h000, 4'h0, 1'b1);
        check("pushpop_occ2", 256'(dut.occ), 256'(2));
        for (int i = 0; i < 4; i++) stepr(1'b0, 9'h000, 4'h0, 1'b1);

        // Random traffic with random backpressure
        cnt = 0; cyc = 0;
        while (cnt < 1000 && cyc < 10000) begin
            stepr($urandom_range(0, 3) != 0, 9'($urandom), 4'($urandom), 1'($urandom));
            if (s_acc) cnt++;
            cyc++;
        end
        check("rand_accepted", 256'(cnt), 256'(1000));
        for (int i = 0; i < 8; i++) stepr(1'b0, 9'h000, 4'h0, 1'b1);
        check("rand_drained", 256'(exp_q.size()), 256'(0));

        // Reset with one read in flight and two entries queued
        for (int i = 0; i < 3; i++) stepr(1'b1, 9'(96 + i), 4'(i), 1'b0);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        clkrst_mem_rst = 1'b1;
        #2;
        check("rst2_resp_valid", 256'(bus.resp_valid), 256'(1'b0));
        check("rst2_req_ready", 256'(bus.req_ready), 256'(1'b1));
        check("rst2_resp_data", bus.resp_data, 256'h0);
        m_occ = 0;
        m_inflight = 1'b0;
        exp_q.delete();
        @(posedge clkrst_mem_clk);
        #1;
        clkrst_mem_rst = 1'b0;
        check("rst2_after_valid", 256'(bus.resp_valid), 256'(1'b0));
        for (int i = 0; i < 3; i++) stepr(1'b0, 9'h000, 4'h0, 1'b1);
        stepr(1'b1, 9'h033, 4'h7, 1'b1);
        stepr(1'b0, 9'h000, 4'h0, 1'b1);
        stepr(1'b0, 9'h000, 4'h0, 1'b1);
        exp_line = pat(9'h033);
        check("rst2_new_pop", 256'(s_pop), 256'(1'b1));
        check("rst2_new_data", s_data, exp_line);
        check("rst2_new_tag", 256'(s_tag), 256'(4'h7));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
